// File: rtl/alu_slice_seq.sv
// Digit-serial ALU: one SLICE-bit digit per clock, carry chained
// through a register, valid/ready on both sides, status flags.
module alu_slice_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r1,
  output logic             c_out,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}});

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_out_q, c_out_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [31:0]      sh;
  logic [SLICE-1:0] sa, sb, bop, slice_r;
  logic [SLICE:0]   sum;
  logic             cout, cmsb, last, inv_b;
  logic [WIDTH-1:0] nres;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept in IDLE, NSLICE digits in RUN, hold in DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and result outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    r1        = res_q;
    c_out     = c_out_q;
    zero      = zero_q;
    ovf       = ovf_q;
    err       = err_q;
  end

  // One digit of the operation plus operand/flag capture
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    c_out_d = c_out_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    sh    = 32'(cnt_q) * SLICE;
    sa    = SLICE'(a_q >> sh);
    sb    = SLICE'(b_q >> sh);
    inv_b = (op_q == OP_SUB) || (op_q == OP_SLTU);
    bop   = inv_b ? ~sb : sb;
    sum   = {1'b0, sa} + {1'b0, bop} + {{SLICE{1'b0}}, cy_q};
    cout  = sum[SLICE];
    cmsb  = sa[SLICE-1] ^ bop[SLICE-1] ^ sum[SLICE-1];
    last  = (cnt_q == CW'(NSLICE - 1));

    unique case (op_q)
      OP_PASS: slice_r = sa;
      OP_NOT:  slice_r = ~sa;
      OP_ADD:  slice_r = sum[SLICE-1:0];
      OP_SUB:  slice_r = sum[SLICE-1:0];
      OP_OR:   slice_r = sa | sb;
      OP_AND:  slice_r = sa & sb;
      OP_SLTU: slice_r = '0;
      OP_ILL:  slice_r = '0;
      default: slice_r = '0;
    endcase

    nres = (res_q & ~(MASK << sh)) | (WIDTH'(slice_r) << sh);
    if (op_q == OP_SLTU && last)
      nres = {{(WIDTH-1){1'b0}}, ~cout};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = ALUop;
          a_d     = r2;
          b_d     = r3;
          cy_d    = (ALUop == OP_SUB) || (ALUop == OP_SLTU);
          cnt_d   = '0;
          res_d   = '0;
          c_out_d = 1'b0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        res_d = nres;
        cy_d  = cout;
        if (last) begin
          c_out_d = (op_q == OP_ADD) ? cout :
                    (op_q == OP_SUB) ? ~cout : 1'b0;
          ovf_d   = (op_q == OP_ADD || op_q == OP_SUB) &
                    (cmsb ^ cout);
          zero_d  = (nres == '0);
          err_d   = (op_q == OP_ILL);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      c_out_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      c_out_q <= c_out_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_slice_seq.sv
// Randomised self-checking bench for alu_slice_seq
// (WIDTH=8, SLICE=2) against an arithmetic reference model.
module tb_alu_slice_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] ALUop;
  logic [7:0] r2, r3;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] r1;
  logic       c_out, zero, ovf, err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_slice_seq #(.WIDTH(8), .SLICE(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .r2(r2), .r3(r3),
    .out_valid(out_valid), .out_ready(out_ready),
    .r1(r1), .c_out(c_out), .zero(zero),
    .ovf(ovf), .err(err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on whole operands
  task automatic model(input logic [2:0] op,
                       input logic [7:0] a, b,
                       output logic [7:0] r,
                       output logic c, z, v, e);
    logic [8:0] s;
    c = 0; v = 0; e = 0; r = 0;
    case (op)
      3'd0: r = a;
      3'd1: r = ~a;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd3: begin
        r = a - b;
        c = (a < b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd4: r = a | b;
      3'd5: r = a & b;
      3'd6: r = (a < b) ? 8'd1 : 8'd0;
      default: e = 1;
    endcase
    z = (r == 0);
  endtask

  task automatic run_op(input logic [2:0] op,
                        input logic [7:0] a, b,
                        input int hold);
    logic [7:0] er;
    logic ec, ez, ev, ee;
    int lat;
    string t;
    model(op, a, b, er, ec, ez, ev, ee);
    t = $sformatf("op%0d %h,%h", op, a, b);
    @(negedge clk);
    check({t, " in_ready"}, in_ready, 1);
    in_valid = 1; ALUop = op; r2 = a; r3 = b;
    out_ready = 0;
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = $urandom_range(0, 1);
      ALUop = 3'($urandom);
      r2 = 8'($urandom); r3 = 8'($urandom);
      check({t, " run in_ready"}, in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check({t, " latency"}, lat, 4);
    check({t, " r1"}, r1, er);
    check({t, " c_out"}, c_out, ec);
    check({t, " zero"}, zero, ez);
    check({t, " ovf"}, ovf, ev);
    check({t, " err"}, err, ee);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; ALUop = 3'($urandom);
      r2 = 8'($urandom); r3 = 8'($urandom);
      @(negedge clk);
      check({t, " hold out_valid"}, out_valid, 1);
      check({t, " hold in_ready"}, in_ready, 0);
      check({t, " hold flags"},
            {r1, c_out, zero, ovf, err},
            {er, ec, ez, ev, ee});
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    check({t, " release out_valid"}, out_valid, 0);
    check({t, " release in_ready"}, in_ready, 1);
    out_ready = 0;
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst = 1; in_valid = 0; out_ready = 0;
    ALUop = 0; r2 = 0; r3 = 0;
    #12;
    check("reset outs",
          {out_valid, r1, c_out, zero, ovf, err}, 0);
    check("reset in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;

    run_op(3'd2, 8'hF0, 8'h20, 0);
    run_op(3'd3, 8'h05, 8'h07, 0);
    run_op(3'd6, 8'h05, 8'h07, 0);
    run_op(3'd3, 8'h80, 8'h01, 0);
    run_op(3'd0, 8'hA5, 8'h0F, 0);
    run_op(3'd1, 8'hA5, 8'h0F, 0);
    run_op(3'd4, 8'hA5, 8'h0F, 0);
    run_op(3'd5, 8'hA5, 8'h0F, 0);
    run_op(3'd3, 8'h33, 8'h33, 3);
    run_op(3'd7, 8'h12, 8'h34, 1);
    run_op(3'd2, 8'h01, 8'h01, 0);

    // Asynchronous reset while slice 2 is pending
    @(negedge clk);
    in_valid = 1; ALUop = 3'd2; r2 = 8'hFF; r3 = 8'hFF;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("midrst outs",
          {out_valid, r1, c_out, zero, ovf, err}, 0);
    check("midrst in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("midrst no out_valid", seen, 0);

    for (int k = 0; k < 40; k++)
      run_op(3'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 2));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_slice_seq.md
Name: alu_slice_seq

Overview:
- Parametrised digit-serial ALU: next generation of the single-bit ALU slice.
- Processes a WIDTH-bit operation SLICE bits per clock, with the carry held in a register between slices.
- Valid/ready handshake on input and output; adds status flags (carry/borrow, zero, overflow, illegal-op).
- Sits between the register-read stage and writeback in the datapath; trades latency for area.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per clock; NSLICE = WIDTH/SLICE, at least 1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- ALUop  input  3  opcode
- r2  input  WIDTH  operand A
- r3  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- r1  output  WIDTH  result
- c_out  output  1  ADD: carry out; SUB: borrow (= NOT carry of r2+~r3+1); else 0
- zero  output  1  r1 == 0
- ovf  output  1  signed overflow for ADD/SUB; else 0
- err  output  1  illegal opcode executed

Behaviour:
- Opcodes:
  - 000: r2
  - 001: ~r2
  - 010: r2+r3
  - 011: r2+~r3+1
  - 100: r2|r3
  - 101: r2&r3
  - 110: SLTU, r1 = {0..., (r2<r3 unsigned)}, i.e. borrow of r2-r3
  - 111: illegal
- FSM states IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: all outputs 0 except in_ready = 1.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: capture r2, r3, ALUop; carry register = 1 for 011/110, else 0; slice counter = 0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge processes slice cnt: bits [cnt*SLICE +: SLICE] of the captured operands, with carry chained from the previous slice.
  - Result bits are written into the result register at the same position; the counter increments.
  - After the edge processing slice NSLICE-1: go to DONE and register the flags.
- DONE:
  - out_valid=1, and r1 and the flags are stable.
  - out_valid && out_ready at an edge: go to IDLE, out_valid=0.
  - Outputs hold their values while out_ready=0.
- Latency: out_valid asserts exactly NSLICE clocks after the accepting edge.
- Throughput: one op per NSLICE+2 clocks minimum.
- No overlap: in_ready=0 in RUN and in DONE, including the cycle in which out_ready is high.
- Flags:
  - ovf = carry into MSB XOR carry out of MSB, for ADD/SUB only.
  - c_out per port definition.
  - zero computed on the final r1 for every opcode, including SLTU and illegal.
- Illegal 111: runs the full NSLICE cycles; r1=0, err=1, c_out=0, ovf=0, zero=1. Never drives X.
- err clears on the next accepted op.
- SLICE=WIDTH (NSLICE=1): RUN lasts one cycle; behaviour is otherwise identical.
- Counter wrap: the counter is reset on accept; it never wraps within an op.
- Reset mid-operation (RUN or DONE): immediately IDLE and all outputs at reset values. The in-flight op is discarded with no result produced.
- in_valid while not in IDLE is ignored; the operands are not sampled.

Test Plan:
- All tests use WIDTH=8, SLICE=2 (NSLICE=4).
- ADD r2=8'hF0, r3=8'h20 -> out_valid exactly 4 clocks after accept; r1=8'h10, c_out=1, ovf=0, zero=0.
- SUB r2=8'h05, r3=8'h07 -> r1=8'hFE, c_out=1. SLTU same operands -> r1=8'h01. SUB r2=8'h80, r3=8'h01 -> r1=8'h7F, ovf=1, c_out=0.
- Sweep PASS/NOT/OR/AND with r2=8'hA5, r3=8'h0F -> results 8'hA5, 8'h5A, 8'hAF, 8'h05. SUB 8'h33-8'h33 -> r1=0, zero=1.
- Backpressure:
  - Hold out_ready=0 for 3 clocks in DONE -> r1 and flags stable, in_ready=0, and new in_valid ignored.
  - Raise out_ready -> IDLE next clock, in_ready=1.
- Assert rst asynchronously in RUN at slice 2 -> outputs 0 and in_ready=1 before the next edge; no out_valid follows.
- ALUop=111 -> r1=0, err=1, zero=1 after 4 clocks. Next ADD 8'h01+8'h01 -> r1=8'h02, err=0.
